button_debounce: RTL and testbench
==================================

# button_debounce

Conditions one raw board push-button into clean, single-cycle control events for the LED blink stage. It synchronises the asynchronous button to `sys_clk`, filters contact bounce with a stability counter, and emits registered press, release and long-press pulses. `press_pulse` drives the blink stage's pause toggle input, so one physical press produces exactly one toggle.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive stable cycles required to accept a level change (20 ms at 50 MHz). Must be ≥ 2.
- `LONG_CYCLES`, default 50_000_000: number of held cycles, counted from accepted press, before `long_pulse` fires (1 s). Must be > `DEBOUNCE_CYCLES`.
- `ACTIVE_LOW`, default 1: 1 means the button reads 0 when pressed.
- `sys_clk`  input  1  system clock; sole clock domain.
- `rst`  input  1  synchronous, active-high reset.
- `btn_in`  input  1  raw, asynchronous, bouncing button pin.
- `btn_level`  output  1  debounced level; 1 = pressed.
- `press_pulse`  output  1  one-cycle pulse when a press is accepted.
- `release_pulse`  output  1  one-cycle pulse when a release is accepted.
- `long_pulse`  output  1  one-cycle pulse, at most once per press, when the hold reaches `LONG_CYCLES`.

## Operation
- **Synchroniser**
  - Two flops on `btn_in`.
  - `s` = second flop output, XOR `ACTIVE_LOW`, so `s` = 1 means pressed.
  - On reset, both flops load the released pin level (`ACTIVE_LOW`).
- **FSM states:** RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- **Counters**
  - `db_cnt`: debounce counter, width $clog2(DEBOUNCE_CYCLES).
  - `hold_cnt`: hold counter, width $clog2(LONG_CYCLES).
  - Both are unsigned and never wrap.
- **RELEASED**
  - `s`=1 → PRESS_WAIT, `db_cnt`←0.
- **PRESS_WAIT**
  - `s`=0 → RELEASED (bounce rejected, no pulse).
  - Else if `db_cnt`==DEBOUNCE_CYCLES-1 → PRESSED, `btn_level`←1, `press_pulse`←1, `hold_cnt`←0, `long_fired`←0.
  - Else `db_cnt`++.
- **PRESSED**
  - `s`=0 → RELEASE_WAIT, `db_cnt`←0.
  - `hold_cnt` increments whenever the FSM is in PRESSED or RELEASE_WAIT, until it saturates at LONG_CYCLES-1.
  - When `hold_cnt`==LONG_CYCLES-1 and `long_fired`=0: `long_pulse`←1, `long_fired`←1.
- **RELEASE_WAIT**
  - `s`=1 → PRESSED (release bounce rejected). `hold_cnt` and `long_fired` are retained; no new `press_pulse`.
  - Else if `db_cnt`==DEBOUNCE_CYCLES-1 → RELEASED, `btn_level`←0, `release_pulse`←1.
  - Else `db_cnt`++.
- **Pulse outputs**
  - All pulses are registered, high for exactly one cycle, and default to 0 on every other cycle.
  - `press_pulse` and `release_pulse` are never high in the same cycle.
  - `long_pulse` may coincide with neither of them. It can only fire at least one cycle after `press_pulse`, because `LONG_CYCLES` > 1.
- **Reset**
  - Reset at any time, including mid-debounce or mid-hold, forces: state RELEASED, `db_cnt`=0, `hold_cnt`=0, `long_fired`=0, synchroniser to the released level.
  - Pulses pending at that point are dropped; no release pulse is generated.
  - A button still held when reset deasserts is re-debounced from scratch and then yields a fresh `press_pulse`.

## Timing
- **Reset values:** `btn_level`=0, `press_pulse`=0, `release_pulse`=0, `long_pulse`=0; state RELEASED. Reset takes effect on the first `sys_clk` rising edge with `rst`=1.
- **Press latency:** take the first edge sampling the new pressed pin level as edge 1.
  - `s` reflects the new level after edge 2.
  - PRESS_WAIT is entered at edge 3.
  - `press_pulse` and `btn_level` rise after edge DEBOUNCE_CYCLES+3.
- **Release latency:** identical, DEBOUNCE_CYCLES+3 edges to `release_pulse` and the `btn_level` fall.
- **Bounce rejection:** any opposite-level sample at `s` during a wait state restarts the qualification. The required stable window is DEBOUNCE_CYCLES consecutive `s` samples.
- **Long-press latency:** `long_pulse` rises LONG_CYCLES-1 cycles after `press_pulse` when the button is held continuously.
- **Minimum event spacing:** consecutive accepted presses are at least 2·(DEBOUNCE_CYCLES+1) cycles apart.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1.

- **Reset:** hold `rst`=1 for 3 cycles with `btn_in`=1 → all outputs 0. Release reset with the button idle for 50 cycles → no pulses.
- **Clean press/release:** drive `btn_in` 1→0 and hold → `press_pulse` high for exactly 1 cycle after the 7th edge, and `btn_level`=1. Then drive 0→1 → `release_pulse` after 7 edges, and `btn_level`=0.
- **Bounce:** drive `btn_in`=0 for 3 cycles, 1 for 1 cycle, then 0 steady → only one `press_pulse`, 7 edges after the final falling edge. A 0/1 toggle every cycle for 40 cycles → no pulse at all.
- **Long press:** hold `btn_in`=0 for 60 cycles → `press_pulse` once, then `long_pulse` once exactly 19 cycles later, then nothing more. Release with a 2-cycle bounce mid-debounce → `long_pulse` does not repeat, and exactly one `release_pulse` follows.
- **Reset mid-operation:** assert `rst` for 1 cycle while in PRESS_WAIT, with the button held → no pulse during reset. `press_pulse` then arrives 7 edges after the first post-reset edge.
- **Repeated presses:** 5 clean presses, each with 12-cycle low and 12-cycle high phases → exactly 5 `press_pulse` and 5 `release_pulse`, with no `long_pulse`.

Source files
------------

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Brief    : Synchronises and debounces one push-button; emits registered
//            press, release and long-press single-cycle pulses.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int c_HOLD_W = $clog2(LONG_CYCLES);

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_CYCLES - 1);
    localparam logic                c_IDLE_LVL  = (ACTIVE_LOW != 0);

    localparam logic [1:0] c_ST_RELEASED     = 2'd0;
    localparam logic [1:0] c_ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_PRESSED      = 2'd2;
    localparam logic [1:0] c_ST_RELEASE_WAIT = 2'd3;

    logic [1:0]          r_state;
    logic                r_sync1;
    logic                r_sync2;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_long_fired;
    logic                r_level;
    logic                r_press;
    logic                r_release;
    logic                r_long;

    logic                w_s;
    logic [c_HOLD_W-1:0] w_hold_next;

    assign w_s         = r_sync2 ^ c_IDLE_LVL;
    assign w_hold_next = (r_hold_cnt == c_HOLD_LAST) ? r_hold_cnt : r_hold_cnt + 1'b1;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state      <= c_ST_RELEASED;
            r_sync1      <= c_IDLE_LVL;
            r_sync2      <= c_IDLE_LVL;
            r_db_cnt     <= '0;
            r_hold_cnt   <= '0;
            r_long_fired <= 1'b0;
            r_level      <= 1'b0;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_long       <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_sync1   <= btn_in;
            r_sync2   <= r_sync1;

            if (r_state == c_ST_PRESSED || r_state == c_ST_RELEASE_WAIT) begin
                r_hold_cnt <= w_hold_next;
            end

            case (r_state)
                c_ST_RELEASED: begin
                    if (w_s) begin
                        r_state  <= c_ST_PRESS_WAIT;
                        r_db_cnt <= '0;
                    end
                end
                c_ST_PRESS_WAIT: begin
                    if (!w_s) begin
                        r_state <= c_ST_RELEASED;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_state      <= c_ST_PRESSED;
                        r_level      <= 1'b1;
                        r_press      <= 1'b1;
                        r_hold_cnt   <= '0;
                        r_long_fired <= 1'b0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                c_ST_PRESSED: begin
                    if (!w_s) begin
                        r_state  <= c_ST_RELEASE_WAIT;
                        r_db_cnt <= '0;
                    end
                    // Fire in PRESSED only, so long never lands on a release edge.
                    if (!r_long_fired && w_hold_next == c_HOLD_LAST) begin
                        r_long       <= 1'b1;
                        r_long_fired <= 1'b1;
                    end
                end
                c_ST_RELEASE_WAIT: begin
                    if (w_s) begin
                        r_state <= c_ST_PRESSED;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_state   <= c_ST_RELEASED;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: r_state <= c_ST_RELEASED;
            endcase
        end
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debounce
// Brief    : Directed self-checking bench for button_debounce (DB=4, LONG=20).
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

    logic sys_clk;
    logic rst;
    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_press  = 0;
    int n_rel    = 0;
    int n_long   = 0;
    int n_clash  = 0;
    int t_press  = -1;
    int t_rel    = -1;
    int t_long   = -1;

    button_debounce #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .ACTIVE_LOW     (1)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Pulse-cycle counters: a pulse held for two cycles counts twice.
    always @(negedge sys_clk) begin
        if (press_pulse === 1'b1) begin
            n_press = n_press + 1;
            t_press = cyc;
        end
        if (release_pulse === 1'b1) begin
            n_rel = n_rel + 1;
            t_rel = cyc;
        end
        if (long_pulse === 1'b1) begin
            n_long = n_long + 1;
            t_long = cyc;
        end
        if ((long_pulse === 1'b1 && (press_pulse === 1'b1 || release_pulse === 1'b1)) ||
            (press_pulse === 1'b1 && release_pulse === 1'b1))
            n_clash = n_clash + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int t0;
        int p0;
        int r0;
        int l0;

        rst    = 1'b1;
        btn_in = 1'b1;
        wait_cycles(3);
        check("rst_level",   int'(btn_level),     0);
        check("rst_press",   int'(press_pulse),   0);
        check("rst_release", int'(release_pulse), 0);
        check("rst_long",    int'(long_pulse),    0);

        rst = 1'b0;
        wait_cycles(50);
        check("idle_press",   n_press, 0);
        check("idle_release", n_rel,   0);
        check("idle_long",    n_long,  0);

        // Clean press and release
        t0 = cyc; btn_in = 1'b0;
        wait_cycles(10);
        check("clean_press_cnt", n_press, 1);
        check("clean_press_lat", t_press - t0, 7);
        check("clean_level_hi",  int'(btn_level), 1);
        t0 = cyc; btn_in = 1'b1;
        wait_cycles(10);
        check("clean_rel_cnt",  n_rel, 1);
        check("clean_rel_lat",  t_rel - t0, 7);
        check("clean_level_lo", int'(btn_level), 0);

        // Bounce on press: 3 low, 1 high, then low
        p0 = n_press;
        btn_in = 1'b0; wait_cycles(3);
        btn_in = 1'b1; wait_cycles(1);
        t0 = cyc; btn_in = 1'b0;
        wait_cycles(15);
        check("bounce_press_cnt", n_press - p0, 1);
        check("bounce_press_lat", t_press - t0, 7);
        btn_in = 1'b1;
        wait_cycles(15);

        // Toggle every cycle: never stable long enough
        p0 = n_press; r0 = n_rel;
        for (int i = 0; i < 40; i++) begin
            btn_in = (i % 2 == 0) ? 1'b0 : 1'b1;
            wait_cycles(1);
        end
        btn_in = 1'b1;
        wait_cycles(10);
        check("toggle_press", n_press - p0, 0);
        check("toggle_rel",   n_rel - r0,   0);
        check("toggle_level", int'(btn_level), 0);

        // Long press, then release with a 2-cycle bounce mid-debounce
        p0 = n_press; r0 = n_rel; l0 = n_long;
        btn_in = 1'b0;
        wait_cycles(60);
        check("long_press_cnt", n_press - p0, 1);
        check("long_cnt",       n_long - l0,  1);
        check("long_lat",       t_long - t_press, 19);
        btn_in = 1'b1; wait_cycles(2);
        btn_in = 1'b0; wait_cycles(2);
        btn_in = 1'b1; wait_cycles(15);
        check("long_no_repeat", n_long - l0, 1);
        check("long_rel_cnt",   n_rel - r0,  1);
        check("long_level_lo",  int'(btn_level), 0);

        // Reset while in PRESS_WAIT with the button held
        p0 = n_press;
        btn_in = 1'b0;
        wait_cycles(4);
        rst = 1'b1;
        wait_cycles(1);
        check("midrst_no_press", n_press - p0, 0);
        check("midrst_level",    int'(btn_level), 0);
        t0 = cyc; rst = 1'b0;
        wait_cycles(10);
        check("midrst_press_cnt", n_press - p0, 1);
        check("midrst_press_lat", t_press - t0, 7);
        btn_in = 1'b1;
        wait_cycles(12);

        // Repeated clean presses
        p0 = n_press; r0 = n_rel; l0 = n_long;
        for (int i = 0; i < 5; i++) begin
            btn_in = 1'b0; wait_cycles(12);
            btn_in = 1'b1; wait_cycles(12);
        end
        check("rep_press", n_press - p0, 5);
        check("rep_rel",   n_rel - r0,   5);
        check("rep_long",  n_long - l0,  0);
        check("rep_level", int'(btn_level), 0);

        check("pulse_overlap", n_clash, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
